// File: rtl/motoron_pkg.sv
// Shared types and constants for the multi-phase motor commutation driver.
// Holds the controller state encoding, PWM period and step-index width.
package motoron_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BRAKE = 2'd2
   } state_t;

   localparam int PWM_PERIOD = 100;
   localparam int PWM_W      = 7;
   localparam int STEP_W     = 4;

endpackage

// File: rtl/motoron_phase_out.sv
// One phase leg: PWM gating and registered gate enables, 1 clock from mode/command, no backpressure.
// With MOTORO_DEADTIME_EN both gates are held off for DEADCYC clocks whenever the conducting side flips.
module motoron_phase_out
   import motoron_pkg::*;
`ifdef MOTORO_DEADTIME_EN
#(
   parameter int DEADCYC = 10
)
`endif
(
   input  logic   clk,
   input  logic   rst,
   input  state_t mode,
   input  logic   cmd_high,
   input  logic   pwm_on,
   output logic   hp,
   output logic   lp
);

   logic hp_nxt;
   logic lp_nxt;

   always_comb begin
      hp_nxt = 1'b0;
      lp_nxt = 1'b0;
      case (mode)
         RUN: begin
            hp_nxt = cmd_high & pwm_on;
            lp_nxt = ~cmd_high;
         end
         BRAKE:   lp_nxt = 1'b1;
         default: ;
      endcase
   end

`ifdef MOTORO_DEADTIME_EN
   typedef enum logic [1:0] {SIDE_NONE, SIDE_HIGH, SIDE_LOW} side_t;
   localparam int DTW = $clog2(DEADCYC + 1);

   side_t          req_side;
   side_t          last_side;
   logic [DTW-1:0] dt_cnt;

   // PWM chopping stays on the high side, so only the commanded side matters here
   always_comb begin
      req_side = SIDE_NONE;
      if (mode == BRAKE || (mode == RUN && !cmd_high)) req_side = SIDE_LOW;
      else if (mode == RUN)                            req_side = SIDE_HIGH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hp        <= 1'b0;
         lp        <= 1'b0;
         dt_cnt    <= '0;
         last_side <= SIDE_NONE;
      end else if (dt_cnt != '0) begin
         hp     <= 1'b0;
         lp     <= 1'b0;
         dt_cnt <= dt_cnt - 1'b1;
      end else if (req_side != SIDE_NONE && last_side != SIDE_NONE && req_side != last_side) begin
         hp        <= 1'b0;
         lp        <= 1'b0;
         dt_cnt    <= DTW'(DEADCYC - 1);
         last_side <= req_side;
      end else begin
         hp <= hp_nxt;
         lp <= lp_nxt;
         if (req_side != SIDE_NONE) last_side <= req_side;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         hp <= 1'b0;
         lp <= 1'b0;
      end else begin
         hp <= hp_nxt;
         lp <= lp_nxt;
      end
   end
`endif

endmodule

// File: rtl/motoron_driver.sv
// NPH-phase commutation driver: RUN/BRAKE/IDLE control, step timer, PWM; gate outputs 1 clock after state/step.
// No backpressure; optional dead-time insertion via MOTORO_DEADTIME_EN.
module motoron_driver
   import motoron_pkg::*;
#(
   parameter int NPH         = 3,
   parameter int CNTW        = 25,
   parameter int RELOAD_INIT = 100000,
   parameter int RELOAD_MIN  = 100,
   parameter int RELOAD_MAX  = 10000000,
   parameter int RELOAD_STEP = 100,
   parameter int DEADCYC     = 10
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            m3start,
   input  logic            m3forceStop,
   input  logic            m3invRotate,
   input  logic            m3freqINC,
   input  logic            m3freqDEC,
   input  logic [7:0]      powerPercent,
   output logic [NPH-1:0]  hp,
   output logic [NPH-1:0]  lp,
   output logic [3:0]      stepIdx,
   output logic [1:0]      state,
   output logic [CNTW-1:0] reload
);

   localparam int NSTEP = 2 * NPH;
   localparam int SW1   = STEP_W + 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);
   localparam logic [CNTW-1:0]   R_INIT    = CNTW'(RELOAD_INIT);
   localparam logic [CNTW-1:0]   R_MIN     = CNTW'(RELOAD_MIN);
   localparam logic [CNTW-1:0]   R_MAX     = CNTW'(RELOAD_MAX);
   localparam logic [CNTW-1:0]   R_STEP    = CNTW'(RELOAD_STEP);

   if (NPH < 2 || NPH > 8) begin : g_bad_nph
      $error("motoron_driver: NPH must be in 2..8");
   end
   if (DEADCYC < 1) begin : g_bad_dead
      $error("motoron_driver: DEADCYC must be at least 1");
   end

   state_t            cur_state;
   state_t            nxt_state;
   logic              dir_rev;
   logic [CNTW-1:0]   step_cnt;
   logic [PWM_W-1:0]  pwm_cnt;
   logic [STEP_W-1:0] next_step;
   logic              pwm_on;

   always_comb begin
      nxt_state = cur_state;
      if (m3forceStop) begin
         nxt_state = BRAKE;
      end else begin
         case (cur_state)
            IDLE:    if (m3start)  nxt_state = RUN;
            RUN:     if (!m3start) nxt_state = IDLE;
            BRAKE:   nxt_state = IDLE;
            default: nxt_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cur_state <= IDLE;
      else     cur_state <= nxt_state;
   end

   assign next_step = dir_rev ? ((stepIdx == '0) ? LAST_STEP : stepIdx - 1'b1)
                              : ((stepIdx == LAST_STEP) ? '0 : stepIdx + 1'b1);

   // direction is latched only while stopped so a mid-run flip cannot reverse the field
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_rev  <= 1'b0;
         stepIdx  <= '0;
         step_cnt <= '0;
      end else begin
         if (cur_state == IDLE) dir_rev <= m3invRotate;
         if (cur_state == IDLE && nxt_state == RUN) begin
            stepIdx  <= '0;
            step_cnt <= reload;
         end else if (cur_state == RUN) begin
            if (step_cnt == '0) begin
               step_cnt <= reload;
               stepIdx  <= next_step;
            end else begin
               step_cnt <= step_cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reload <= R_INIT;
      end else if (m3freqINC && !m3freqDEC) begin
         reload <= (reload <= R_MIN + R_STEP) ? R_MIN : reload - R_STEP;
      end else if (m3freqDEC && !m3freqINC) begin
         reload <= (reload >= R_MAX - R_STEP) ? R_MAX : reload + R_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                    pwm_cnt <= '0;
      else if (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) pwm_cnt <= '0;
      else                                        pwm_cnt <= pwm_cnt + 1'b1;
   end

   // duty above 100 saturates naturally because pwm_cnt never exceeds 99
   assign pwm_on = {1'b0, pwm_cnt} < powerPercent;
   assign state  = cur_state;

   for (genvar k = 0; k < NPH; k++) begin : g_ph
      localparam logic [SW1-1:0] OFS = SW1'((2 * k) % NSTEP);
      logic [SW1-1:0] rel;
      logic           cmd_high;

      assign rel = ({1'b0, stepIdx} >= OFS) ? {1'b0, stepIdx} - OFS
                                            : {1'b0, stepIdx} + SW1'(NSTEP) - OFS;
      assign cmd_high = rel < SW1'(NPH);

      motoron_phase_out
`ifdef MOTORO_DEADTIME_EN
         #(.DEADCYC(DEADCYC))
`endif
      u_out (
         .clk      (clk),
         .rst      (rst),
         .mode     (cur_state),
         .cmd_high (cmd_high),
         .pwm_on   (pwm_on),
         .hp       (hp[k]),
         .lp       (lp[k])
      );
   end

endmodule
